// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin pick among N,E,W,S,L requesters,
// grant held until the packet's tail flit, gated by a local downstream credit count.
module output_port_allocator #(
    parameter int unsigned CREDIT_MAX = 3,
    parameter int unsigned CNT_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       req,
    input  logic [4:0]       tail,
    input  logic             credit_in,
    output logic [4:0]       grant,
    output logic             flit_valid,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             busy,
    output logic [2:0]       owner,
    output logic             credit_err
);

    localparam int unsigned N_IN = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [2:0]       PTR_RST = 3'(N_IN - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state_q, state_n;
    logic [2:0] owner_q, owner_n;
    logic [2:0] rr_q, rr_n;
    logic [4:0] others;

    // First set bit of mask scanning ptr+1, ptr+2, ... modulo N_IN.
    function automatic logic [2:0] rr_pick(input logic [4:0] mask, input logic [2:0] ptr);
        logic [2:0]  sel;
        logic        found;
        int unsigned idx;
        logic [2:0]  idx3;
        sel   = 3'd0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            idx3 = 3'(idx);
            if (!found && mask[idx3]) begin
                sel   = idx3;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 3'd0;
            rr_q    <= PTR_RST;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            rr_q    <= rr_n;
        end
    end

    // Next-state and grant logic; depends only on registered state, req, tail and credit count.
    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        rr_n    = rr_q;
        grant   = 5'd0;
        others  = req & ~(5'd1 << owner_q);
        case (state_q)
            IDLE: begin
                if (req != 5'd0) begin
                    state_n = LOCKED;
                    owner_n = rr_pick(req, rr_q);
                end
            end
            LOCKED: begin
                if (req[owner_q] && (credit_cnt != '0)) begin
                    grant[owner_q] = 1'b1;
                    if (tail[owner_q]) begin
                        rr_n = owner_q;
                        // Back-to-back handoff avoids an idle bubble between packets.
                        if (others != 5'd0) begin
                            owner_n = rr_pick(others, owner_q);
                        end else begin
                            state_n = IDLE;
                            owner_n = 3'd0;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = 3'd0;
            end
        endcase
    end

    assign flit_valid = |grant;
    assign busy       = (state_q == LOCKED);
    assign owner      = owner_q;

    // Downstream credit counter; saturates at CREDIT_MAX and flags overflow stickily.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_cnt <= CNT_MAX;
            credit_err <= 1'b0;
        end else if (credit_in && !flit_valid) begin
            if (credit_cnt == CNT_MAX) credit_err <= 1'b1;
            else                       credit_cnt <= credit_cnt + CNT_ONE;
        end else if (!credit_in && flit_valid) begin
            credit_cnt <= credit_cnt - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed table-driven bench for the wormhole output-port allocator.
module tb_output_port_allocator;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] req, tail;
    logic       credit_in;
    logic [4:0] grant;
    logic       flit_valid;
    logic [1:0] credit_cnt;
    logic       busy;
    logic [2:0] owner;
    logic       credit_err;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    typedef struct {
        logic       rst;
        logic [4:0] rq;
        logic [4:0] tl;
        logic       ci;
        logic [4:0] g;
        logic       b;
        logic [2:0] o;
        logic [1:0] c;
        logic       e;
    } vec_t;

    vec_t tbl[$];

    output_port_allocator #(.CREDIT_MAX(3), .CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .flit_valid (flit_valid),
        .credit_cnt (credit_cnt),
        .busy       (busy),
        .owner      (owner),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string name, input logic r, input logic [4:0] rq, input logic [4:0] tl,
                       input logic ci, input logic [4:0] eg, input logic eb, input logic [2:0] eo,
                       input logic [1:0] ec, input logic ee);
        reset = r; req = rq; tail = tl; credit_in = ci;
        #3;
        chk({name, ".grant"},      8'(grant),      8'(eg));
        chk({name, ".flit_valid"}, 8'(flit_valid), 8'(|eg));
        chk({name, ".busy"},       8'(busy),       8'(eb));
        chk({name, ".owner"},      8'(owner),      8'(eo));
        chk({name, ".credit_cnt"}, 8'(credit_cnt), 8'(ec));
        chk({name, ".credit_err"}, 8'(credit_err), 8'(ee));
        @(posedge clk); #1;
    endtask

    // Invariants: grant one-hot or zero, never sends without credit.
    always @(negedge clk) begin
        if (started && reset) begin
            checks++;
            if (!$onehot0(grant) || (flit_valid && credit_cnt == 2'd0) || credit_cnt > 2'd3) begin
                errors++;
                $display("FAIL invariant: grant=%b credit_cnt=%0d", grant, credit_cnt);
            end
        end
    end

    initial begin
        reset = 1'b0; req = 5'd0; tail = 5'd0; credit_in = 1'b0;

        // rst, req, tail, ci | grant, busy, owner, cnt, err
        // reset held two cycles
        tbl.push_back('{1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0});
        // N and E single-flit packets back to back, credits returned as flits leave
        tbl.push_back('{1'b1, 5'h03, 5'h1f, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 5'h03, 5'h1f, 1'b0, 5'h01, 1'b1, 3'd0, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 5'h03, 5'h1f, 1'b1, 5'h02, 1'b1, 3'd1, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 5'h03, 5'h1f, 1'b1, 5'h01, 1'b1, 3'd0, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 5'h03, 5'h1f, 1'b1, 5'h02, 1'b1, 3'd1, 2'd2, 1'b0});
        // owner N holds lock with no request; credit refill then overflow
        tbl.push_back('{1'b1, 5'h00, 5'h1f, 1'b1, 5'h00, 1'b1, 3'd0, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 5'h00, 5'h00, 1'b1, 5'h00, 1'b1, 3'd0, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 5'h00, 5'h00, 1'b0, 5'h00, 1'b1, 3'd0, 2'd3, 1'b1});
        tbl.push_back('{1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 1'b1, 3'd0, 2'd3, 1'b1});
        tbl.push_back('{1'b1, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0});
        // N 3-flit packet, tail on third
        tbl.push_back('{1'b1, 5'h01, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 5'h01, 5'h00, 1'b0, 5'h01, 1'b1, 3'd0, 2'd3, 1'b0});
        tbl.push_back('{1'b1, 5'h01, 5'h00, 1'b0, 5'h01, 1'b1, 3'd0, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 5'h01, 5'h01, 1'b0, 5'h01, 1'b1, 3'd0, 2'd1, 1'b0});
        tbl.push_back('{1'b1, 5'h00, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 2'd1, 1'b0});
        tbl.push_back('{1'b1, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 2'd2, 1'b0});

        @(posedge clk); #1;
        started = 1'b1;
        foreach (tbl[i]) begin
            cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rq, tbl[i].tl, tbl[i].ci,
                tbl[i].g, tbl[i].b, tbl[i].o, tbl[i].c, tbl[i].e);
        end

        // W 5-flit packet exhausting credits; credit at zero does not grant that cycle
        cyc("w_idle",  1'b1, 5'h04, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0);
        cyc("w_f1",    1'b1, 5'h04, 5'h00, 1'b0, 5'h04, 1'b1, 3'd2, 2'd3, 1'b0);
        cyc("w_f2",    1'b1, 5'h04, 5'h00, 1'b0, 5'h04, 1'b1, 3'd2, 2'd2, 1'b0);
        cyc("w_f3",    1'b1, 5'h04, 5'h00, 1'b0, 5'h04, 1'b1, 3'd2, 2'd1, 1'b0);
        cyc("w_stall", 1'b1, 5'h04, 5'h00, 1'b0, 5'h00, 1'b1, 3'd2, 2'd0, 1'b0);
        cyc("w_cr4",   1'b1, 5'h04, 5'h00, 1'b1, 5'h00, 1'b1, 3'd2, 2'd0, 1'b0);
        cyc("w_f4",    1'b1, 5'h04, 5'h00, 1'b0, 5'h04, 1'b1, 3'd2, 2'd1, 1'b0);
        cyc("w_stal2", 1'b1, 5'h04, 5'h04, 1'b0, 5'h00, 1'b1, 3'd2, 2'd0, 1'b0);
        cyc("w_cr5",   1'b1, 5'h04, 5'h04, 1'b1, 5'h00, 1'b1, 3'd2, 2'd0, 1'b0);
        cyc("w_f5",    1'b1, 5'h04, 5'h04, 1'b0, 5'h04, 1'b1, 3'd2, 2'd1, 1'b0);
        cyc("w_done",  1'b1, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 2'd0, 1'b0);
        cyc("w_ref1",  1'b1, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 2'd1, 1'b0);
        cyc("w_ref2",  1'b1, 5'h00, 5'h00, 1'b1, 5'h00, 1'b0, 3'd0, 2'd2, 1'b0);

        // Reset mid-packet while locked on S, then N wins over S from reset pointer
        cyc("s_idle",  1'b1, 5'h08, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0);
        cyc("s_f1",    1'b1, 5'h08, 5'h00, 1'b0, 5'h08, 1'b1, 3'd3, 2'd3, 1'b0);
        cyc("s_rst",   1'b0, 5'h09, 5'h00, 1'b0, 5'h08, 1'b1, 3'd3, 2'd2, 1'b0);
        cyc("s_post",  1'b1, 5'h09, 5'h00, 1'b0, 5'h00, 1'b0, 3'd0, 2'd3, 1'b0);
        cyc("s_n1st",  1'b1, 5'h09, 5'h00, 1'b0, 5'h01, 1'b1, 3'd0, 2'd3, 1'b0);

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
